rf_acq_sequencer: RTL and testbench
===================================

// Module: rf_acq_sequencer
// PURPOSE
//  Sequences the 4-channel RF sample source (count/inc_count ROM, registered val outputs) for one
//  acquisition frame: per line, realigns source address to 0, issues num_samples read-advance strobes
//  under downstream backpressure, tags each returned sample with line/sample indices, then moves to
//  next line. Sits between the acquisition control FSM and the RF source feeding the beamformer.
// PARAMETERS
//  SAMPLE_W     16     width of sample counters / num_samples
//  LINE_W       8      width of line counters / num_lines
//  SRC_LATENCY  1      cycles from inc_count high to matching sample on source val outputs (1..4)
//  MAX_SAMPLES  24100  source address space; num_samples clamped to this
// PORTS
//  clk           in   1         rising-edge clock
//  reset         in   1         synchronous, active-high
//  start         in   1         1-cycle pulse; latch config and begin frame (IDLE only)
//  abort         in   1         terminate frame, return to IDLE
//  num_samples   in   SAMPLE_W  samples per line, latched on accepted start
//  num_lines     in   LINE_W    lines per frame, latched on accepted start
//  gap_cycles    in   SAMPLE_W  idle cycles between lines (RF_SEQ_LINE_GAP_EN only)
//  out_ready     in   1         downstream can take a sample SRC_LATENCY cycles from now
//  src_reset     out  1         reset to RF source; clears its address to 0
//  inc_count     out  1         read-advance strobe to RF source
//  sample_valid  out  1         RF source val1..val4 hold a frame sample this cycle
//  sample_idx    out  SAMPLE_W  index within line of the valid sample
//  line_idx      out  LINE_W    line index of the valid sample
//  line_last     out  1         with sample_valid: last sample of the line
//  busy          out  1         state != IDLE
//  done          out  1         1-cycle pulse: frame completed normally
// BEHAVIOUR
//  Reset: state=IDLE; src_reset, inc_count, sample_valid, line_last, busy, done=0; sample_idx, line_idx=0;
//   valid delay pipe cleared.
//  States: IDLE -> PRIME -> RUN -> DRAIN -> {PRIME | GAP | DONE} -> IDLE.
//  IDLE: start=1 latches ns=min(num_samples,MAX_SAMPLES), nl=num_lines. ns==0 or nl==0 -> DONE (no
//   src_reset, no inc_count); else -> PRIME. start while busy ignored.
//  PRIME: exactly 1 cycle, src_reset=1; issue counter cleared; -> RUN.
//  RUN: inc_count = out_ready & (issued < ns), combinational on out_ready, registered state otherwise.
//   Each strobe increments issued; after strobe ns-1 accepted -> DRAIN. inc_count never high in any
//   other state.
//  Data pipe: strobe at cycle t -> sample_valid at cycle t+SRC_LATENCY, sample_idx = issue index,
//   line_idx = current line, line_last = (idx==ns-1). Downstream must absorb SRC_LATENCY in flight.
//  DRAIN: wait until pipe empty (last sample_valid emitted). Then line_idx+1 < nl -> PRIME (or GAP);
//   else -> DONE.
//  DONE: done=1 for 1 cycle, -> IDLE. busy=1 in all states but IDLE.
//  abort (any non-IDLE state): -> IDLE next edge; inc_count=0 same cycle; pipe flushed, no further
//   sample_valid; no done. abort and start same cycle in IDLE: start wins, abort ignored.
//  reset mid-frame: same as power-up reset; src_reset not asserted by reset itself.
//  Counters: issued/sample_idx wrap never occurs (clamped ns <= MAX_SAMPLES < 2^SAMPLE_W).
// CONFIGURATION
//  RF_SEQ_LINE_GAP_EN defined: gap_cycles port exists, latched on start; DRAIN -> GAP for g cycles
//   (g==0: GAP skipped) then -> PRIME; models TX fire/settle between lines.
//  Not defined: port absent, DRAIN goes straight to PRIME; lines back-to-back.
// TESTING
//  T1: ns=12, nl=1, out_ready=1 -> 1 src_reset, 12 contiguous inc_count, sample_valid idx 0..11 each
//   1 cycle after strobe, line_last on idx 11, done 1 cycle after last valid.
//  T2: ns=4, nl=3 -> 3 PRIME pulses, 12 valids, line_idx 0,0,0,0,1,...,2; one done.
//  T3: ns=8, out_ready toggling 1010... -> inc_count only on ready cycles, 8 valids, idx gap-free.
//  T4: ns=0 or nl=0 -> done 1 cycle after start, zero inc_count/src_reset/valid.
//  T5: abort after 5 strobes of ns=10 -> inc_count low same cycle, busy low next, no done, <=1 valid
//   after abort.
//  T6: RF_SEQ_LINE_GAP_EN, ns=2, nl=2, g=3 -> exactly 3 idle cycles between DRAIN exit and 2nd src_reset.

Source files
------------

// File: rtl/rf_acq_sequencer.sv
// Frame sequencer for the 4-channel RF sample source: per-line address realign, throttled read strobes,
// sample tagging. Optional inter-line gap state is enabled by defining RF_SEQ_LINE_GAP_EN.
module rf_acq_sequencer #(
  parameter int SAMPLE_W    = 16,
  parameter int LINE_W      = 8,
  parameter int SRC_LATENCY = 1,
  parameter int MAX_SAMPLES = 24100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic [LINE_W-1:0]   num_lines,
`ifdef RF_SEQ_LINE_GAP_EN
  input  logic [SAMPLE_W-1:0] gap_cycles,
`endif
  input  logic                out_ready,
  output logic                src_reset,
  output logic                inc_count,
  output logic                sample_valid,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic [LINE_W-1:0]   line_idx,
  output logic                line_last,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef RF_SEQ_LINE_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd5;
`endif

  localparam logic [SAMPLE_W-1:0] MAX_NS = SAMPLE_W'(MAX_SAMPLES);

  function automatic logic [SAMPLE_W-1:0] clamp_ns(input logic [SAMPLE_W-1:0] n);
    return (n > MAX_NS) ? MAX_NS : n;
  endfunction

  logic [2:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] ns_q, ns_d;
  logic [LINE_W-1:0]   nl_q, nl_d;
  logic [SAMPLE_W-1:0] issued_q, issued_d;
  logic [LINE_W-1:0]   line_q, line_d;
`ifdef RF_SEQ_LINE_GAP_EN
  logic [SAMPLE_W-1:0] gap_q, gap_d;
  logic [SAMPLE_W-1:0] gcnt_q, gcnt_d;
`endif

  logic                vld_p_q  [SRC_LATENCY];
  logic [SAMPLE_W-1:0] idx_p_q  [SRC_LATENCY];
  logic [LINE_W-1:0]   lidx_p_q [SRC_LATENCY];
  logic                last_p_q [SRC_LATENCY];

  logic                abort_hit;
  logic                pending;
  logic                last_issue;
  logic                more_lines;
  logic [SAMPLE_W-1:0] start_ns;

  assign abort_hit  = abort && (state_q != S_IDLE);
  assign last_issue = (issued_q == (ns_q - SAMPLE_W'(1)));
  assign more_lines = (({1'b0, line_q} + (LINE_W+1)'(1)) < {1'b0, nl_q});
  assign start_ns   = clamp_ns(num_samples);

  // Strobe follows out_ready combinationally so backpressure takes effect in the same cycle.
  assign inc_count = (state_q == S_RUN) && out_ready && (issued_q < ns_q) && !abort;

  // Samples still travelling toward the output stage; the output stage itself is being emitted now.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < SRC_LATENCY - 1; i++) begin
      pending = pending | vld_p_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    ns_d     = ns_q;
    nl_d     = nl_q;
    issued_d = issued_q;
    line_d   = line_q;
`ifdef RF_SEQ_LINE_GAP_EN
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ns_d   = start_ns;
          nl_d   = num_lines;
          line_d = '0;
`ifdef RF_SEQ_LINE_GAP_EN
          gap_d  = gap_cycles;
`endif
          state_d = ((start_ns == '0) || (num_lines == '0)) ? S_DONE : S_PRIME;
        end
      end
      S_PRIME: begin
        issued_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (inc_count) begin
          issued_d = issued_q + SAMPLE_W'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          if (more_lines) begin
            line_d = line_q + LINE_W'(1);
`ifdef RF_SEQ_LINE_GAP_EN
            if (gap_q != '0) begin
              gcnt_d  = gap_q;
              state_d = S_GAP;
            end else begin
              state_d = S_PRIME;
            end
`else
            state_d = S_PRIME;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end
`ifdef RF_SEQ_LINE_GAP_EN
      S_GAP: begin
        gcnt_d = gcnt_q - SAMPLE_W'(1);
        if (gcnt_q == SAMPLE_W'(1)) state_d = S_PRIME;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ns_q     <= '0;
      nl_q     <= '0;
      issued_q <= '0;
      line_q   <= '0;
`ifdef RF_SEQ_LINE_GAP_EN
      gap_q    <= '0;
      gcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ns_q     <= ns_d;
      nl_q     <= nl_d;
      issued_q <= issued_d;
      line_q   <= line_d;
`ifdef RF_SEQ_LINE_GAP_EN
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
`endif
    end
  end

  // Valid delay pipe matching the source read latency; abort drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset || abort_hit) begin
      for (int i = 0; i < SRC_LATENCY; i++) vld_p_q[i] <= 1'b0;
    end else begin
      vld_p_q[0] <= inc_count;
      for (int i = 1; i < SRC_LATENCY; i++) vld_p_q[i] <= vld_p_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SRC_LATENCY; i++) begin
        idx_p_q[i]  <= '0;
        lidx_p_q[i] <= '0;
        last_p_q[i] <= 1'b0;
      end
    end else begin
      idx_p_q[0]  <= issued_q;
      lidx_p_q[0] <= line_q;
      last_p_q[0] <= inc_count && last_issue;
      for (int i = 1; i < SRC_LATENCY; i++) begin
        idx_p_q[i]  <= idx_p_q[i-1];
        lidx_p_q[i] <= lidx_p_q[i-1];
        last_p_q[i] <= last_p_q[i-1];
      end
    end
  end

  assign sample_valid = vld_p_q[SRC_LATENCY-1];
  assign sample_idx   = idx_p_q[SRC_LATENCY-1];
  assign line_idx     = lidx_p_q[SRC_LATENCY-1];
  assign line_last    = vld_p_q[SRC_LATENCY-1] && last_p_q[SRC_LATENCY-1];
  assign src_reset    = (state_q == S_PRIME);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_rf_acq_sequencer.sv
// Scoreboard bench for rf_acq_sequencer: stimulus pushes expected samples, a monitor pops on sample_valid.
module tb_rf_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [15:0] num_samples;
  logic [7:0]  num_lines;
`ifdef RF_SEQ_LINE_GAP_EN
  logic [15:0] gap_cycles;
`endif
  logic        src_reset, inc_count, sample_valid, line_last, busy, done;
  logic [15:0] sample_idx;
  logic [7:0]  line_idx;

  always #5 clk = ~clk;

  rf_acq_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_samples  (num_samples),
    .num_lines    (num_lines),
`ifdef RF_SEQ_LINE_GAP_EN
    .gap_cycles   (gap_cycles),
`endif
    .out_ready    (out_ready),
    .src_reset    (src_reset),
    .inc_count    (inc_count),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .line_idx     (line_idx),
    .line_last    (line_last),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  line;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_n = 0;
  int   cnt_inc = 0, cnt_srst = 0, cnt_done = 0, cnt_vld = 0;
  int   first_inc_cyc = -1, last_inc_cyc = -1, last_vld_cyc = -1, done_cyc = -1;
  int   srst_cyc_q[$];
  int   last_cyc_q[$];
  logic inc_prev = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, event counters, latency and backpressure checks.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      inc_prev = 1'b0;
    end else begin
      if (inc_count) begin
        cnt_inc++;
        if (first_inc_cyc < 0) first_inc_cyc = cyc_n;
        last_inc_cyc = cyc_n;
        check("inc_count needs out_ready", out_ready, 1);
      end
      if (src_reset) begin
        cnt_srst++;
        srst_cyc_q.push_back(cyc_n);
      end
      if (done) begin
        cnt_done++;
        done_cyc = cyc_n;
      end
      if (sample_valid || inc_prev) check("valid one cycle after strobe", sample_valid, inc_prev);
      if (sample_valid) begin
        cnt_vld++;
        last_vld_cyc = cyc_n;
        if (line_last) last_cyc_q.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb: unexpected sample idx %0d line %0d, none expected", sample_idx, line_idx);
        end else begin
          e = exp_q.pop_front();
          check("sb sample_idx", sample_idx, e.idx);
          check("sb line_idx", line_idx, e.line);
          check("sb line_last", line_last, e.last);
        end
      end
      inc_prev = inc_count;
    end
  end

  task automatic run_frame(input string nm, input logic [15:0] ns_in, input logic [7:0] nl_in,
                           input int exp_ns, input int exp_inc, input int exp_srst,
                           input int mode, input bit poke, input bit ab);
    int b_inc, b_srst, b_done, b_vld, t_start;
    bit got;
    exp_t e;
    for (int l = 0; l < int'(nl_in); l++) begin
      for (int i = 0; i < exp_ns; i++) begin
        e.idx  = 16'(i);
        e.line = 8'(l);
        e.last = (i == exp_ns - 1);
        exp_q.push_back(e);
      end
    end
    b_inc = cnt_inc; b_srst = cnt_srst; b_done = cnt_done; b_vld = cnt_vld;
    first_inc_cyc = -1;
    num_samples = ns_in;
    num_lines   = nl_in;
    out_ready   = 1'b1;
    start       = 1'b1;
    abort       = ab;
    t_start     = cyc_n;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 30000 && !got; i++) begin
      out_ready = (mode == 1) ? ((i % 2) == 0) : 1'b1;
      if (poke && i == 5) begin
        start       = 1'b1;
        num_samples = 16'd3;
      end else begin
        start = 1'b0;
      end
      cyc();
      if (cnt_done != b_done) got = 1'b1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    check({nm, " done seen"}, got, 1);
    check({nm, " inc_count count"}, cnt_inc - b_inc, exp_inc);
    check({nm, " src_reset count"}, cnt_srst - b_srst, exp_srst);
    check({nm, " done count"}, cnt_done - b_done, 1);
    check({nm, " valid count"}, cnt_vld - b_vld, exp_ns * int'(nl_in));
    check({nm, " scoreboard drained"}, exp_q.size(), 0);
    if (exp_inc == 0) check({nm, " done latency from start"}, done_cyc - t_start, 1);
    else check({nm, " done after last valid"}, done_cyc - last_vld_cyc, 1);
    if (mode == 0 && nl_in == 8'd1 && exp_inc > 0)
      check({nm, " strobes contiguous"}, last_inc_cyc - first_inc_cyc, exp_inc - 1);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_inc, b_done, b_vld;
    exp_t e;
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    num_samples = '0; num_lines = '0;
`ifdef RF_SEQ_LINE_GAP_EN
    gap_cycles = '0;
`endif
    repeat (3) cyc();
    @(negedge clk);
    check("reset src_reset", src_reset, 0);
    check("reset inc_count", inc_count, 0);
    check("reset sample_valid", sample_valid, 0);
    check("reset line_last", line_last, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sample_idx", sample_idx, 0);
    check("reset line_idx", line_idx, 0);
    cyc();
    reset = 1'b0;
    cyc();

    run_frame("T1", 16'd12, 8'd1, 12, 12, 1, 0, 0, 0);
    run_frame("T2", 16'd4, 8'd3, 4, 12, 3, 0, 1, 0);
    run_frame("T3", 16'd8, 8'd1, 8, 8, 1, 1, 0, 0);
    run_frame("T4 ns0", 16'd0, 8'd5, 0, 0, 0, 0, 0, 0);
    run_frame("T4 nl0", 16'd7, 8'd0, 7, 0, 0, 0, 0, 0);
    run_frame("start+abort", 16'd2, 8'd1, 2, 2, 1, 0, 0, 1);
    run_frame("clamp", 16'hFFFF, 8'd1, 24100, 24100, 1, 0, 0, 0);

    // T5: abort in the cycle that would carry the sixth strobe.
    for (int i = 0; i < 5; i++) begin
      e.idx = 16'(i); e.line = 8'd0; e.last = 1'b0;
      exp_q.push_back(e);
    end
    b_inc = cnt_inc; b_done = cnt_done; b_vld = cnt_vld;
    num_samples = 16'd10; num_lines = 8'd1; out_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (6) cyc();
    check("T5 strobes before abort", cnt_inc - b_inc, 5);
    abort = 1'b1;
    @(negedge clk);
    check("T5 inc_count low with abort", inc_count, 0);
    check("T5 busy during abort cycle", busy, 1);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    check("T5 busy after abort", busy, 0);
    repeat (5) cyc();
    check("T5 no done", cnt_done - b_done, 0);
    check("T5 valids", cnt_vld - b_vld, 5);
    check("T5 scoreboard drained", exp_q.size(), 0);
    exp_q.delete();

    // Reset in the middle of a frame.
    for (int i = 0; i < 20; i++) begin
      e.idx = 16'(i); e.line = 8'd0; e.last = (i == 19);
      exp_q.push_back(e);
    end
    b_done = cnt_done;
    num_samples = 16'd20; num_lines = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    check("midreset busy", busy, 0);
    check("midreset sample_valid", sample_valid, 0);
    check("midreset src_reset", src_reset, 0);
    check("midreset sample_idx", sample_idx, 0);
    exp_q.delete();
    repeat (4) cyc();
    check("midreset no done", cnt_done - b_done, 0);

`ifdef RF_SEQ_LINE_GAP_EN
    srst_cyc_q.delete();
    last_cyc_q.delete();
    gap_cycles = 16'd3;
    run_frame("T6", 16'd2, 8'd2, 2, 4, 2, 0, 0, 0);
    if (srst_cyc_q.size() >= 2 && last_cyc_q.size() >= 1)
      check("T6 gap idle cycles", srst_cyc_q[1] - last_cyc_q[0] - 1, 3);
    else
      check("T6 gap events seen", srst_cyc_q.size(), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
